// File: rtl/btn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_ctrl_pkg
//  Purpose  : Shared types and default sizing for the front-panel button
//             controller (state encoding, divider/debounce/timeout widths).
//  Revision : 1.0  initial release
// ============================================================================
package btn_ctrl_pkg;

  // Run/stop state of the controller; en is driven straight from this.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default sizing used when the top is instantiated without overrides.
  localparam int c_div_bits = 16;
  localparam int c_db_depth = 4;
  localparam int c_to_bits  = 8;

endpackage
`default_nettype wire

// File: rtl/btn_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : btn_ctrl_if
//  Purpose  : Bundle of the raw pushbutton inputs and the en/speed control
//             outputs. master = controller side, slave = board/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface btn_ctrl_if;
  logic btn_en;
  logic btn_speed;
  logic en;
  logic speed;
  logic en_pulse;
  logic speed_pulse;

  modport master (
    input  btn_en,
    input  btn_speed,
    output en,
    output speed,
    output en_pulse,
    output speed_pulse
  );

  modport slave (
    output btn_en,
    output btn_speed,
    input  en,
    input  speed,
    input  en_pulse,
    input  speed_pulse
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Tick-sampled shift-register debouncer for one raw button with a
//             rising-edge one-pulse on the debounced level.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_DEPTH = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_tick,
  input  wire logic i_raw,
  output logic      o_level,
  output logic      o_pulse
);

  logic [DB_DEPTH-1:0] r_shift;
  logic [DB_DEPTH-1:0] w_shift_nxt;
  logic                r_level;
  logic                r_level_d;

  // The level decision looks at the register contents including the sample
  // being shifted in now, so the level moves on the same edge as the
  // DB_DEPTH-th matching sample rather than one tick later.
  assign w_shift_nxt = {r_shift[DB_DEPTH-2:0], i_raw};

  // Sample the raw input on each tick and update the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_level <= 1'b0;
    end else if (i_tick) begin
      r_shift <= w_shift_nxt;
      if (&w_shift_nxt) begin
        r_level <= 1'b1;
      end else if (~|w_shift_nxt) begin
        r_level <= 1'b0;
      end
    end
  end

  // One-cycle delayed copy of the level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : btn_ctrl
//  Purpose  : Front-panel controller. Debounces the run/stop and speed
//             buttons, turns presses into single-cycle strobes and drives the
//             level-type en/speed controls for the LED pattern block.
//  Options  : BTN_CTRL_AUTOSTOP_EN - drop back to idle after 2^TO_BITS
//             sample ticks in RUN without any button press.
//  Revision : 1.0  initial release
// ============================================================================
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int DIV_BITS = c_div_bits,
  parameter int DB_DEPTH = c_db_depth,
  parameter int TO_BITS  = c_to_bits
) (
  input wire logic  clk,
  input wire logic  rst,
  btn_ctrl_if.master bus
);

  logic [DIV_BITS-1:0] r_div;
  logic                w_tick;
  logic                w_en_pulse;
  logic                w_speed_pulse;
  logic                w_en_level_unused;
  logic                w_speed_level_unused;
  logic                w_timeout;
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_speed;
  logic                w_speed_nxt;

  // Free-running sample divider; tick fires on the all-ones count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = &r_div;

  btn_debounce #(
    .DB_DEPTH (DB_DEPTH)
  ) u_db_en (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (w_tick),
    .i_raw   (bus.btn_en),
    .o_level (w_en_level_unused),
    .o_pulse (w_en_pulse)
  );

  btn_debounce #(
    .DB_DEPTH (DB_DEPTH)
  ) u_db_speed (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (w_tick),
    .i_raw   (bus.btn_speed),
    .o_level (w_speed_level_unused),
    .o_pulse (w_speed_pulse)
  );

`ifdef BTN_CTRL_AUTOSTOP_EN
  logic [TO_BITS-1:0] r_to;

  // Ticks spent in RUN since the last press; any press or leaving RUN restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to <= '0;
    end else if (w_en_pulse || w_speed_pulse || (r_state != ST_RUN)) begin
      r_to <= '0;
    end else if (w_tick) begin
      r_to <= r_to + 1'b1;
    end
  end

  // A press in the same cycle takes priority over the timeout.
  assign w_timeout = w_tick && (r_state == ST_RUN) && (&r_to)
                     && !w_en_pulse && !w_speed_pulse;
`else
  localparam int c_to_bits_unused = TO_BITS;
  assign w_timeout = 1'b0;
`endif

  // State and speed registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_speed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_speed <= w_speed_nxt;
    end
  end

  // Next state: en press toggles run/stop and swallows a coincident speed press.
  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
    case (r_state)
      ST_IDLE: begin
        if (w_en_pulse) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_en_pulse) begin
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_speed_pulse) begin
            w_speed_nxt = ~r_speed;
          end
          if (w_timeout) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.en          = (r_state == ST_RUN);
  assign bus.speed       = r_speed;
  assign bus.en_pulse    = w_en_pulse;
  assign bus.speed_pulse = w_speed_pulse;

endmodule
`default_nettype wire

// File: tb/tb_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_ctrl
//  Purpose  : Self-checking bench for btn_ctrl: behavioural reference model
//             checked every cycle plus directed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_ctrl;
  localparam int DIV = 2;
  localparam int DB  = 4;
  localparam int TO  = 3;
  localparam int TICK_PERIOD = 1 << DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_ctrl_if bus ();

  btn_ctrl #(
    .DIV_BITS (DIV),
    .DB_DEPTH (DB),
    .TO_BITS  (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_en_pulse = 0;
  int n_sp_pulse = 0;

  // Reference model: index 0 = en button, 1 = speed button.
  int m_cyc;
  bit m_last   [2];
  int m_runlen [2];
  bit m_lvl    [2];
  bit m_lvl_d  [2];
  bit m_run;
  bit m_speed;
  int m_idle_ticks;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cyc = 0;
    for (int b = 0; b < 2; b++) begin
      m_last[b]   = 1'b0;
      m_runlen[b] = DB;     // cleared history counts as a full run of lows
      m_lvl[b]    = 1'b0;
      m_lvl_d[b]  = 1'b0;
    end
    m_run        = 1'b0;
    m_speed      = 1'b0;
    m_idle_ticks = 0;
  endfunction

  // Compare DUT against the model each cycle, then advance the model to
  // what the next rising edge must produce.
  always @(negedge clk) begin
    bit raw [2];
    bit pe, ps, tick, timeout;
    if (rst) model_reset();
    chk("en",          bus.en,          m_run);
    chk("speed",       bus.speed,       m_speed);
    chk("en_pulse",    bus.en_pulse,    m_lvl[0] & ~m_lvl_d[0]);
    chk("speed_pulse", bus.speed_pulse, m_lvl[1] & ~m_lvl_d[1]);
    if (bus.en_pulse === 1'b1)    n_en_pulse++;
    if (bus.speed_pulse === 1'b1) n_sp_pulse++;
    if (!rst) begin
      pe   = m_lvl[0] & ~m_lvl_d[0];
      ps   = m_lvl[1] & ~m_lvl_d[1];
      tick = (m_cyc % TICK_PERIOD) == (TICK_PERIOD - 1);
      m_cyc++;
      raw[0] = bus.btn_en;
      raw[1] = bus.btn_speed;
      for (int b = 0; b < 2; b++) begin
        m_lvl_d[b] = m_lvl[b];
        if (tick) begin
          if (raw[b] == m_last[b]) begin
            m_runlen[b] = (m_runlen[b] < DB) ? m_runlen[b] + 1 : DB;
          end else begin
            m_last[b]   = raw[b];
            m_runlen[b] = 1;
          end
          if (m_runlen[b] >= DB) m_lvl[b] = m_last[b];
        end
      end
      timeout = 1'b0;
`ifdef BTN_CTRL_AUTOSTOP_EN
      if (pe || ps || !m_run) begin
        m_idle_ticks = 0;
      end else if (tick) begin
        m_idle_ticks++;
        if (m_idle_ticks == (1 << TO)) begin
          timeout      = 1'b1;
          m_idle_ticks = 0;
        end
      end
`endif
      if (pe) begin
        m_run = !m_run;
      end else begin
        if (ps && m_run) m_speed = !m_speed;
        if (timeout)     m_run   = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int which, input int hold, input int gap);
    if (which == 0) bus.btn_en = 1'b1; else bus.btn_speed = 1'b1;
    step(hold);
    if (which == 0) bus.btn_en = 1'b0; else bus.btn_speed = 1'b0;
    step(gap);
  endtask

  initial begin
    int p0;
    int found;
    bus.btn_en    = 1'b0;
    bus.btn_speed = 1'b0;
    step(3);
    rst = 1'b0;

    // 1: idle with no buttons
    step(100);
    chk("t1_en", bus.en, 1'b0);
    chk("t1_speed", bus.speed, 1'b0);
    chk_n("t1_pulses", n_en_pulse + n_sp_pulse, 0);

    // 3: bounce faster than the debounce window
    p0 = n_en_pulse;
    for (int i = 0; i < 14; i++) begin
      bus.btn_en = (i % 2 == 0);
      step(3);
    end
    bus.btn_en = 1'b0;
    step(30);
    chk_n("t3_no_pulse", n_en_pulse - p0, 0);
    chk("t3_en", bus.en, 1'b0);

    // 2: long hold -> one pulse, en follows one cycle later
    step(10);
    p0 = n_en_pulse;
    bus.btn_en = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (bus.en_pulse === 1'b1) found = 1;
    end
    chk_n("t2_pulse_seen", found, 1);
    chk("t2_en_at_pulse", bus.en, 1'b0);
    @(negedge clk);
    chk("t2_en_after_pulse", bus.en, 1'b1);
    step(40);
    bus.btn_en = 1'b0;
    step(30);
    chk_n("t2_one_pulse", n_en_pulse - p0, 1);

`ifndef BTN_CTRL_AUTOSTOP_EN
    chk("t2_en_held", bus.en, 1'b1);
    // 4: speed ignored in idle, toggles in run, retained across stop/start
    press(0, 30, 30);
    chk("t4_stopped", bus.en, 1'b0);
    press(1, 30, 30);
    chk("t4_speed_idle", bus.speed, 1'b0);
    press(0, 30, 30);
    chk("t4_running", bus.en, 1'b1);
    press(1, 30, 30);
    chk("t4_speed_run", bus.speed, 1'b1);
    press(0, 30, 30);
    press(0, 30, 30);
    chk("t4_restart_en", bus.en, 1'b1);
    chk("t4_speed_kept", bus.speed, 1'b1);

    // 5: both buttons together from idle
    press(0, 30, 30);
    bus.btn_en    = 1'b1;
    bus.btn_speed = 1'b1;
    step(30);
    bus.btn_en    = 1'b0;
    bus.btn_speed = 1'b0;
    step(30);
    chk("t5_en", bus.en, 1'b1);
    chk("t5_speed", bus.speed, 1'b1);
`endif

    // 6: reset in the middle of a press
    bus.btn_en = 1'b1;
    step(8);
    rst = 1'b1;
    #1;
    chk("t6_en", bus.en, 1'b0);
    chk("t6_speed", bus.speed, 1'b0);
    chk("t6_en_pulse", bus.en_pulse, 1'b0);
    chk("t6_speed_pulse", bus.speed_pulse, 1'b0);
    step(3);
    rst = 1'b0;
    bus.btn_en = 1'b0;
    step(30);
    chk("t6_en_after", bus.en, 1'b0);

    // Run with no further presses: autostop drops en after 8 idle ticks
    press(0, 20, 4);
    chk("t7_en_entered", bus.en, 1'b1);
    step(60);
`ifdef BTN_CTRL_AUTOSTOP_EN
    chk("t7_autostop", bus.en, 1'b0);
`else
    chk("t7_run_persists", bus.en, 1'b1);
`endif

    // Random button activity, checked cycle by cycle against the model
    for (int i = 0; i < 80; i++) begin
      bus.btn_en    = 1'($urandom_range(0, 1));
      bus.btn_speed = 1'($urandom_range(0, 1));
      step($urandom_range(1, 40));
    end
    bus.btn_en    = 1'b0;
    bus.btn_speed = 1'b0;
    step(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
